ad7124_spi_responder: RTL

Synthesizable SPI-slave model of the AD7124-8 serial interface, i.e. the responder end of the TC status/data read path. It answers comms-byte commands from the TC SPI master (mode 3, MSB first) with status, data, ID and ADC_CONTROL contents. The conversion results it serves come from an on-chip sample stream. It is used for FPGA-side loopback bring-up and for closed-loop simulation of the TC read chain without the physical ADC.

---
 rtl/ad7124_pkg.sv | 39 +++
 rtl/ad7124_spi_responder_sync_edge.sv | 54 +++++
 rtl/ad7124_spi_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ad7124_pkg.sv
// Register map, comms-byte layout and FSM state encoding shared by the
// AD7124 SPI responder and its bench-facing helpers.
package ad7124_pkg;

  localparam logic [5:0] ADDR_STATUS      = 6'h00;
  localparam logic [5:0] ADDR_ADC_CONTROL = 6'h01;
  localparam logic [5:0] ADDR_DATA        = 6'h02;
  localparam logic [5:0] ADDR_ID          = 6'h05;

  localparam int STATUS_W   = 8;
  localparam int ADC_CTRL_W = 16;
  localparam int ID_W       = 8;
  localparam int CMD_W      = 8;

  localparam int CMD_WEN_BIT = 7;
  localparam int CMD_RW_BIT  = 6;
  localparam int CMD_ADDR_W  = 6;

  localparam int STATUS_RDY_BIT = 7;
  localparam int STATUS_CH_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } spi_state_e;

  function automatic logic [STATUS_W-1:0] status_byte(input logic rdy_n,
                                                       input logic [STATUS_CH_W-1:0] ch);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_RDY_BIT] = rdy_n;
    s[STATUS_CH_W-1:0] = ch;
    return s;
  endfunction

endpackage

// File: rtl/ad7124_spi_responder_sync_edge.sv
// Brings the asynchronous SPI pins into PL_clk and derives one-cycle
// SCLK rise/fall and chip-select fall/rise pulses from the synchronized levels.
module spi_slave_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic sclk,
  input  logic sdi,
  output logic cs_n_s,
  output logic sdi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] cs_sync_p0;
  logic [SYNC_STAGES-1:0] sclk_sync_p0;
  logic [SYNC_STAGES-1:0] sdi_sync_p0;
  logic                   cs_prev_p1;
  logic                   sclk_prev_p1;
  logic                   sclk_s;

  // Synchronizer chains: pins idle high (CPOL=1, cs deasserted)
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_p0   <= '1;
      sclk_sync_p0 <= '1;
      cs_prev_p1   <= 1'b1;
      sclk_prev_p1 <= 1'b1;
    end else begin
      cs_sync_p0   <= (cs_sync_p0 << 1) | SYNC_STAGES'(cs_n);
      sclk_sync_p0 <= (sclk_sync_p0 << 1) | SYNC_STAGES'(sclk);
      cs_prev_p1   <= cs_n_s;
      sclk_prev_p1 <= sclk_s;
    end
  end

  always_ff @(posedge clk) begin
    sdi_sync_p0 <= (sdi_sync_p0 << 1) | SYNC_STAGES'(sdi);
  end

  // Edge detection on the last synchronizer stage
  assign cs_n_s    = cs_sync_p0[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_p1;
  assign sclk_fall = ~sclk_s & sclk_prev_p1;
  assign cs_fall   = ~cs_n_s & cs_prev_p1;
  assign cs_rise   = cs_n_s & ~cs_prev_p1;

endmodule

// File: rtl/ad7124_spi_responder.sv
// AD7124-8 serial-interface responder: decodes comms bytes from the TC SPI
// master and serves status, data, ID and ADC_CONTROL from an on-chip sample stream.
module ad7124_spi_responder
  import ad7124_pkg::*;
#(
  parameter int          DATA_WD      = 24,
  parameter logic [7:0]  ID_VALUE     = 8'h14,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] ADC_CTRL_RST = 16'h0000
) (
  input  logic               PL_clk,
  input  logic               PL_USER_RST,
  input  logic               TC_cs_n,
  input  logic               TC_sclk,
  input  logic               TC_sdi,
  output logic               TC_sdo,
  output logic               TC_sdo_oe,
  input  logic               sample_valid,
  input  logic [DATA_WD-1:0] sample_data,
  input  logic [3:0]         sample_ch,
  output logic               rdy_n,
  output logic [15:0]        adc_control,
  output logic               rd_data_done,
  output logic               overrun
);

  localparam logic [7:0] CMD_LAST  = 8'(CMD_W - 1);
  localparam logic [7:0] WR_LAST   = 8'(ADC_CTRL_W - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_WD - 1);

  logic cs_n_s, sdi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  spi_slave_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (PL_clk),
    .rst      (PL_USER_RST),
    .cs_n     (TC_cs_n),
    .sclk     (TC_sclk),
    .sdi      (TC_sdi),
    .cs_n_s   (cs_n_s),
    .sdi_s    (sdi_s),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise)
  );

  spi_state_e               state;
  logic [7:0]               bit_cnt;
  logic [CMD_W-2:0]         cmd_sr;
  logic [ADC_CTRL_W-2:0]    wr_sr;
  logic [DATA_WD-1:0]       out_sr;
  logic [DATA_WD-1:0]       data_reg;
  logic [STATUS_CH_W-1:0]   ch_reg;
  logic                     rd_is_data;
  logic                     new_since_snap;

  logic [CMD_W-1:0]         cmd_byte;
  logic [CMD_ADDR_W-1:0]    cmd_addr;
  logic                     cmd_done;
  logic                     rd_ok;
  logic                     wr_ok;
  logic                     load_data;
  logic                     rd_done_set;
  logic [DATA_WD-1:0]       snap;

  assign cmd_byte = {cmd_sr, sdi_s};
  assign cmd_addr = cmd_byte[CMD_ADDR_W-1:0];
  assign cmd_done = (state == ST_CMD) && sclk_rise && !cs_n_s && (bit_cnt == CMD_LAST);

  always_comb begin
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (!cmd_byte[CMD_WEN_BIT]) begin
      if (cmd_byte[CMD_RW_BIT])
        rd_ok = (cmd_addr == ADDR_STATUS) || (cmd_addr == ADDR_ADC_CONTROL) ||
                (cmd_addr == ADDR_DATA) || (cmd_addr == ADDR_ID);
      else
        wr_ok = (cmd_addr == ADDR_ADC_CONTROL);
    end
  end

  // Snapshot is left-aligned and padded with ones so the tail of an over-long read idles high
  always_comb begin
    snap = '1;
    case (cmd_addr)
      ADDR_STATUS:      snap[DATA_WD-1 -: STATUS_W]   = status_byte(rdy_n, ch_reg);
      ADDR_ADC_CONTROL: snap[DATA_WD-1 -: ADC_CTRL_W] = adc_control;
      ADDR_DATA:        snap                          = data_reg;
      ADDR_ID:          snap[DATA_WD-1 -: ID_W]       = ID_VALUE;
      default:          ;
    endcase
  end

  assign load_data   = cmd_done && rd_ok && (cmd_addr == ADDR_DATA);
  assign rd_done_set = (state == ST_RD) && rd_is_data && sclk_rise && !cs_n_s &&
                       (bit_cnt == DATA_LAST);

  // Sample capture and RDY tracking; a sample that lands during a data read keeps RDY low
  always_ff @(posedge PL_clk) begin
    if (PL_USER_RST) begin
      data_reg       <= '0;
      ch_reg         <= '0;
      rdy_n          <= 1'b1;
      new_since_snap <= 1'b0;
      overrun        <= 1'b0;
      rd_data_done   <= 1'b0;
    end else begin
      overrun      <= sample_valid & ~rdy_n;
      rd_data_done <= rd_done_set;
      if (sample_valid) begin
        data_reg <= sample_data;
        ch_reg   <= sample_ch;
        rdy_n    <= 1'b0;
      end else if (rd_done_set && !new_since_snap) begin
        rdy_n <= 1'b1;
      end
      if (sample_valid)
        new_since_snap <= 1'b1;
      else if (load_data)
        new_since_snap <= 1'b0;
    end
  end

  always_ff @(posedge PL_clk) begin
    if (PL_USER_RST) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      wr_sr       <= '0;
      out_sr      <= '1;
      rd_is_data  <= 1'b0;
      TC_sdo      <= 1'b1;
      TC_sdo_oe   <= 1'b0;
      adc_control <= ADC_CTRL_RST;
    end else if (cs_n_s || cs_rise) begin
      state     <= ST_IDLE;
      TC_sdo    <= 1'b1;
      TC_sdo_oe <= 1'b0;
    end else begin
      TC_sdo_oe <= 1'b1;
      case (state)
        ST_IDLE: begin
          TC_sdo <= rdy_n;
          if (cs_fall) begin
            bit_cnt <= '0;
            state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          TC_sdo <= rdy_n;
          if (sclk_rise) begin
            cmd_sr  <= cmd_byte[CMD_W-2:0];
            bit_cnt <= bit_cnt + 8'd1;
            if (cmd_done) begin
              bit_cnt    <= '0;
              rd_is_data <= (cmd_addr == ADDR_DATA);
              if (rd_ok) begin
                out_sr <= snap;
                state  <= ST_RD;
              end else if (wr_ok) begin
                state <= ST_WR;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
        end
        ST_RD: begin
          if (sclk_fall) begin
            TC_sdo <= out_sr[DATA_WD-1];
            out_sr <= {out_sr[DATA_WD-2:0], 1'b1};
          end
          if (sclk_rise && bit_cnt != 8'hFF)
            bit_cnt <= bit_cnt + 8'd1;
        end
        ST_WR: begin
          TC_sdo <= 1'b1;
          if (sclk_rise) begin
            wr_sr   <= {wr_sr[ADC_CTRL_W-3:0], sdi_s};
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == WR_LAST) begin
              adc_control <= {wr_sr, sdi_s};
              state       <= ST_IGNORE;
            end
          end
        end
        default: begin
          TC_sdo <= 1'b1;
        end
      endcase
    end
  end

endmodule
